// File: rtl/matrix_mem_resp.sv
// Solver read responder for the matrix SRAM, with host load-window arbitration.
// Optional MEM_RRDY_THROTTLE_EN adds LFSR-driven ready throttling in SERVE.
module matrix_mem_resp #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mem_rreq,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              o_mem_rrdy,
  output logic [DATA_W-1:0] o_mem_dout,
  output logic              o_mem_dout_vld,
  input  logic              i_ld_req,
  output logic              o_ld_gnt,
  input  logic              i_ld_wen,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_sram_cen,
  output logic              o_sram_wen,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_d,
  input  logic [DATA_W-1:0] i_sram_q,
  output logic [CNT_W-1:0]  o_rd_cnt
);

  localparam logic [1:0] SERVE = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              rrdy_q, rrdy_d;
  logic              gnt_q, gnt_d;
  logic              vld1_q, vld1_d;
  logic              vld2_q, vld2_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [1:0]        infl_q, infl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              rd_acc, wr_acc, ret, stall;

  // Reset suppresses returns already in the pipe so nothing leaks out.
  assign rd_acc = i_mem_rreq & rrdy_q & ~i_reset;
  assign wr_acc = i_ld_wen & gnt_q & ~i_reset;
  assign ret    = vld2_q & ~i_reset;

`ifdef MEM_RRDY_THROTTLE_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0],
              lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    stall  = (lfsr_d[1:0] == 2'b00);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) lfsr_q <= 8'hA5;
    else         lfsr_q <= lfsr_d;
  end
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    infl_d = infl_q;
    unique case (1'b1)
      rd_acc && !ret: infl_d = infl_q + 2'd1;
      !rd_acc && ret: infl_d = infl_q - 2'd1;
      default:        infl_d = infl_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SERVE: if (i_ld_req) state_d = DRAIN;
      DRAIN: begin
        if (!i_ld_req)          state_d = SERVE;
        else if (infl_d == 2'd0) state_d = LOAD;
      end
      LOAD:  if (!i_ld_req) state_d = SERVE;
      default: state_d = SERVE;
    endcase
  end

  always_comb begin
    rrdy_d = (state_d == SERVE) & ~stall;
    gnt_d  = (state_d == LOAD);
    vld1_d = rd_acc;
    vld2_d = vld1_q;
    dout_d = vld1_q ? i_sram_q : '0;
    cnt_d  = cnt_q;
    if (ret && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  // SRAM pins are combinational so an access lands in its request cycle.
  always_comb begin
    addr_d = addr_q;
    wd_d   = wd_q;
    unique case (1'b1)
      wr_acc: begin
        addr_d = i_ld_addr;
        wd_d   = i_ld_data;
      end
      rd_acc:  addr_d = i_mem_addr;
      default: addr_d = addr_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= SERVE;
      rrdy_q  <= 1'b1;
      gnt_q   <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      dout_q  <= '0;
      infl_q  <= 2'd0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      rrdy_q  <= rrdy_d;
      gnt_q   <= gnt_d;
      vld1_q  <= vld1_d;
      vld2_q  <= vld2_d;
      dout_q  <= dout_d;
      infl_q  <= infl_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

  assign o_mem_rrdy     = rrdy_q;
  assign o_mem_dout_vld = ret;
  assign o_mem_dout     = ret ? dout_q : '0;
  assign o_ld_gnt       = gnt_q;
  assign o_sram_cen     = ~(rd_acc | wr_acc);
  assign o_sram_wen     = ~wr_acc;
  assign o_sram_addr    = addr_d;
  assign o_sram_d       = wd_d;
  assign o_rd_cnt       = cnt_q;

endmodule

// File: doc/matrix_mem_resp.md
# matrix_mem_resp

Responder end of the GSIM matrix-memory read port. It accepts read requests from the solver, issues them to a single-port 1024×256 synchronous SRAM macro, and returns each 256-bit row with a valid strobe at a fixed latency. It also arbitrates a host loader that fills the SRAM before or between solves, using `o_mem_rrdy` as the backpressure signal toward the solver.

## Interface
- `ADDR_W`, 10, row address width (SRAM depth = 2^ADDR_W).
- `DATA_W`, 256, row width.
- `CNT_W`, 16, width of the served-read counter.

- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_mem_rreq`  in  1  solver read request.
- `i_mem_addr`  in  ADDR_W  solver row address.
- `o_mem_rrdy`  out  1  registered ready. A read is accepted in any cycle where `i_mem_rreq & o_mem_rrdy`.
- `o_mem_dout`  out  DATA_W  returned row. Forced to 0 whenever `o_mem_dout_vld`=0.
- `o_mem_dout_vld`  out  1  return strobe.
- `i_ld_req`  in  1  host requests the load window (level).
- `o_ld_gnt`  out  1  load window open.
- `i_ld_wen`  in  1  host write strobe. Honoured only while `o_ld_gnt`=1.
- `i_ld_addr`  in  ADDR_W  host write address.
- `i_ld_data`  in  DATA_W  host write data.
- `o_sram_cen`  out  1  SRAM chip enable, active low.
- `o_sram_wen`  out  1  SRAM write enable, active low.
- `o_sram_addr`  out  ADDR_W  SRAM address.
- `o_sram_d`  out  DATA_W  SRAM write data.
- `i_sram_q`  in  DATA_W  SRAM read data. Valid the cycle after a read access.
- `o_rd_cnt`  out  CNT_W  count of served reads. Saturates at all-ones.

## Operation
- FSM states: SERVE, DRAIN, LOAD. Reset state is SERVE.
- **SERVE**
  - `o_mem_rrdy`=1, except when throttled (see Configuration).
  - An accepted read drives the SRAM in the same cycle: `o_sram_cen`=0, `o_sram_wen`=1, `o_sram_addr`=`i_mem_addr`.
  - `i_ld_req`=1 sampled → DRAIN. `o_mem_rrdy` registers to 0 for the next cycle.
  - A read accepted in the same cycle that `i_ld_req` is first seen is still served.
- **DRAIN**
  - `o_mem_rrdy`=0.
  - A 2-bit in-flight counter tracks accepted reads not yet returned: +1 on accept, −1 on `o_mem_dout_vld`, both in the same cycle → unchanged.
  - In-flight count = 0 → LOAD.
  - `i_ld_req` drops while in DRAIN → SERVE.
- **LOAD**
  - `o_ld_gnt`=1 and `o_mem_rrdy`=0.
  - `i_ld_wen`=1 → `o_sram_cen`=0, `o_sram_wen`=0, `o_sram_addr`=`i_ld_addr`, `o_sram_d`=`i_ld_data`.
  - `i_ld_req`=0 → SERVE. `o_ld_gnt` and `o_mem_rrdy` update at the same edge.
  - A write presented in the cycle `i_ld_req` falls is still performed.
- **Idle SRAM:** `o_sram_cen`=1, `o_sram_wen`=1; address and data hold their last value.
- **Return path:** the read-valid flag is pipelined 2 stages. `o_mem_dout` is registered from `i_sram_q` at stage 2.
- **Counter:** `o_rd_cnt` increments on each `o_mem_dout_vld` and holds at 16'hFFFF.
- **Write-enable guard:** `i_ld_wen` outside LOAD is ignored. No SRAM write is issued.
- **Reset mid-operation:**
  - In-flight reads are discarded; no `o_mem_dout_vld` follows.
  - FSM returns to SERVE and the counter clears.

## Timing
- **Read latency:** accepted in cycle k → `o_mem_dout_vld`=1 with data in cycle k+2.
- **Throughput:** back-to-back accepts give back-to-back returns, 1 row/cycle.
- **Reset values:**
  - `o_mem_rrdy`=1, `o_mem_dout_vld`=0, `o_mem_dout`=0.
  - `o_ld_gnt`=0, `o_sram_cen`=1, `o_sram_wen`=1, `o_sram_addr`=0, `o_sram_d`=0.
  - `o_rd_cnt`=0.
- **Load entry:** `i_ld_req` rises in cycle j, with a read accepted in cycle j → DRAIN for cycles j+1 and j+2, `o_ld_gnt`=1 from cycle j+3. With no read in flight, `o_ld_gnt`=1 from cycle j+2.
- **Load exit:** `i_ld_req` low in cycle m → `o_mem_rrdy`=1 in cycle m+1.
- **No overlap:** reads and writes never share an SRAM cycle.

## Configuration
- `MEM_RRDY_THROTTLE_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and advances every cycle.
  - In SERVE, `o_mem_rrdy` is registered as 0 for any cycle where the LFSR's `[1:0]`==2'b00. This exercises solver stall handling.
- Undefined: no LFSR is present, and `o_mem_rrdy`=1 throughout SERVE.

## Test plan
- **Single read:** SRAM row 5 preloaded with 256'h…DEAD; `i_mem_rreq`=1, addr=5 for one cycle (k) → `o_mem_dout_vld`=1 only at k+2, `o_mem_dout`=256'h…DEAD; `o_mem_dout`=0 elsewhere; `o_rd_cnt`=1.
- **Streaming:** 16 consecutive reads, addr 0..15 → 16 contiguous valid cycles in address order, starting 2 cycles after the first accept; `o_rd_cnt`=16.
- **Load during reads:** `i_ld_req` rises in the same cycle as a read of addr 3 → that read returns; `o_mem_rrdy`=0 next cycle; `o_ld_gnt`=1 at j+3; write addr 3 = 256'h1; drop `i_ld_req`; re-read addr 3 → returns 256'h1.
- **Stray write:** `i_ld_wen`=1 while in SERVE → `o_sram_wen` stays 1; SRAM contents unchanged.
- **Reset mid-read:** two reads accepted, then `i_reset` asserted for 1 cycle → no `o_mem_dout_vld` pulse; all outputs at reset values; `o_mem_rrdy`=1 after reset.
- **Throttle (`MEM_RRDY_THROTTLE_EN`):** solver holds `i_mem_rreq`=1 for 200 cycles → `o_mem_rrdy` low exactly in cycles predicted by the LFSR model (seed A5); the return count equals the accept count.
